// File: rtl/fxp_mac_pipe_pkg.sv
// Shared types and constants for the fixed-point multiply / multiply-accumulate pipeline.
package fxp_mac_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_MUL     = 2'b00,
    MODE_MAC     = 2'b01,
    MODE_MAC_CLR = 2'b10,
    MODE_MUL_ALT = 2'b11
  } mode_e;

  localparam bit RND_TRUNC   = 1'b0;
  localparam bit RND_HALF_UP = 1'b1;

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_ADD  = 2'b01,
    ACC_LOAD = 2'b10
  } acc_op_e;

  // Control word that travels alongside the datapath registers.
  typedef struct packed {
    logic    valid;
    acc_op_e op;
  } ctl_t;

  // Reserved mode 11 behaves as a plain multiply.
  function automatic acc_op_e acc_op(input logic [1:0] mode);
    acc_op_e op;
    op = ACC_NONE;
    case (mode)
      MODE_MAC:     op = ACC_ADD;
      MODE_MAC_CLR: op = ACC_LOAD;
      default:      op = ACC_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fxp_mac_pipe_if.sv
// Sample-in / result-out handshake bundle of the fixed-point MAC pipeline.
interface fxp_mac_pipe_if #(
  parameter int unsigned W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic         out_sat;
  logic         acc_ovf;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_p, out_sat, acc_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_p, out_sat, acc_ovf
  );
endinterface

// File: rtl/fxp_mac_pipe_booth_pp_gen.sv
// Radix-4 Booth partial product for one recoded digit, sign-extended to 2W bits before shifting.
module fxp_mac_pipe_booth_pp_gen #(
  parameter int unsigned W = 24
) (
  input  logic [2:0]          digit,
  input  logic signed [W-1:0] b,
  output logic [2*W-1:0]      pp_c
);
  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] b_x;
  assign b_x = PW'(b);

  always_comb begin
    pp_c = '0;
    case (digit)
      3'b001, 3'b010: pp_c = b_x;
      3'b011:         pp_c = b_x <<< 1;
      3'b100:         pp_c = -(b_x <<< 1);
      3'b101, 3'b110: pp_c = -b_x;
      default:        pp_c = '0;
    endcase
  end
endmodule

// File: rtl/fxp_mac_pipe.sv
// Five-stage signed fixed-point MUL/MAC pipeline: input reg, Booth PPs, CSA, add+accumulate, round+saturate.
module fxp_mac_pipe
  import fxp_mac_pipe_pkg::*;
#(
  parameter int unsigned W     = 24,
  parameter int unsigned FRAC  = 22,
  parameter int unsigned GUARD = 4,
  parameter bit          ROUND = RND_HALF_UP
) (
  input logic           clk,
  input logic           rst_n,
  fxp_mac_pipe_if.slave bus
);
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned AW  = PW + GUARD;
  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned NPP = W / 2;
  localparam int unsigned TW  = AW1 - FRAC;

  localparam logic signed [AW:0]   RND_INC = (ROUND == RND_HALF_UP) ? (AW1'(1) << (FRAC - 1)) : '0;
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [W-1:0]         OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         OUT_MIN = {1'b1, {(W-1){1'b0}}};

  logic en;

  ctl_t                ctl1, ctl2, ctl3;
  logic signed [W-1:0] a1, b1;
  logic [PW-1:0]       pp_c [NPP];
  logic [PW-1:0]       pp2  [NPP];
  logic [PW-1:0]       cs_sum_c, cs_car_c;
  logic [PW-1:0]       s3, c3;
  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] prod_x_c;
  logic signed [AW:0]   sum_c;
  logic                 acc_clip_c;
  logic signed [AW-1:0] acc_sat_c;
  logic signed [AW-1:0] acc, r4;
  logic                 v4, ovf;
  logic signed [AW:0]   rnd_c;
  logic signed [TW-1:0] t_c;
  logic [TW-W:0]        t_hi_c;
  logic                 clip_c;
  logic [W-1:0]         p_c;
  logic [W-1:0]         p5;
  logic                 sat5, v5;

  // Whole pipe advances together; a held output freezes every stage.
  assign en            = !v5 || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v5;
  assign bus.out_p     = p5;
  assign bus.out_sat   = sat5;
  assign bus.acc_ovf   = ovf;

  // S1: input capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl1 <= '0;
      a1   <= '0;
      b1   <= '0;
    end else if (en) begin
      ctl1 <= '{valid: bus.in_valid, op: acc_op(bus.in_mode)};
      a1   <= bus.in_a;
      b1   <= bus.in_b;
    end
  end

  // S2: Booth radix-4 recode, a[-1] supplied by the appended zero
  logic [W:0] a1x;
  assign a1x = {a1, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [PW-1:0] raw_c;
    fxp_mac_pipe_booth_pp_gen #(.W(W)) u_pp (
      .digit (a1x[2*i+2 -: 3]),
      .b     (b1),
      .pp_c  (raw_c)
    );
    assign pp_c[i] = raw_c << (2 * i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl2 <= '0;
      for (int i = 0; i < NPP; i++) pp2[i] <= '0;
    end else if (en) begin
      ctl2 <= ctl1;
      for (int i = 0; i < NPP; i++) pp2[i] <= pp_c[i];
    end
  end

  // S3: linear chain of 3:2 rows; carries out of bit PW-1 are dropped (mod 2^PW is exact here)
  always_comb begin
    logic [PW-1:0] s, c, t;
    s = pp2[0];
    c = pp2[1];
    t = '0;
    for (int k = 2; k < NPP; k++) begin
      t = s ^ c ^ pp2[k];
      c = ((s & c) | (s & pp2[k]) | (c & pp2[k])) << 1;
      s = t;
    end
    cs_sum_c = s;
    cs_car_c = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl3 <= '0;
      s3   <= '0;
      c3   <= '0;
    end else if (en) begin
      ctl3 <= ctl2;
      s3   <= cs_sum_c;
      c3   <= cs_car_c;
    end
  end

  // S4: final add and guarded accumulate with clamp at the AW bounds
  assign prod_c     = s3 + c3;
  assign prod_x_c   = AW'(prod_c);
  assign sum_c      = AW1'(acc) + AW1'(prod_x_c);
  assign acc_clip_c = sum_c[AW] != sum_c[AW-1];

  always_comb begin
    acc_sat_c = sum_c[AW-1:0];
    if (acc_clip_c) acc_sat_c = sum_c[AW] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4  <= 1'b0;
      r4  <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      v4 <= ctl3.valid;
      if (ctl3.valid) begin
        case (ctl3.op)
          ACC_ADD: begin
            acc <= acc_sat_c;
            r4  <= acc_sat_c;
            if (acc_clip_c) ovf <= 1'b1;
          end
          ACC_LOAD: begin
            acc <= prod_x_c;
            r4  <= prod_x_c;
            ovf <= 1'b0;
          end
          default: r4 <= prod_x_c;
        endcase
      end
    end
  end

  // S5: round, rescale and clamp to the W-bit result range
  assign rnd_c  = AW1'(r4) + RND_INC;
  assign t_c    = TW'(rnd_c >>> FRAC);
  assign t_hi_c = t_c[TW-1:W-1];
  assign clip_c = !((&t_hi_c) || !(|t_hi_c));
  assign p_c    = clip_c ? (t_c[TW-1] ? OUT_MIN : OUT_MAX) : t_c[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v5   <= 1'b0;
      p5   <= '0;
      sat5 <= 1'b0;
    end else if (en) begin
      v5   <= v4;
      p5   <= p_c;
      sat5 <= clip_c;
    end
  end

endmodule

// File: tb/tb_fxp_mac_pipe.sv
// Directed bench for fxp_mac_pipe: rounding/truncating Q2.22 instances and a narrow W=8 instance.
module tb_fxp_mac_pipe;
  import fxp_mac_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fxp_mac_pipe_if #(.W(24)) if_r ();
  fxp_mac_pipe_if #(.W(24)) if_t ();
  fxp_mac_pipe_if #(.W(8))  if_s ();

  fxp_mac_pipe #(.W(24), .FRAC(22), .GUARD(4), .ROUND(1'b1)) u_dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r));
  fxp_mac_pipe #(.W(24), .FRAC(22), .GUARD(4), .ROUND(1'b0)) u_dut_t (.clk(clk), .rst_n(rst_n), .bus(if_t));
  fxp_mac_pipe #(.W(8),  .FRAC(6),  .GUARD(0), .ROUND(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

  // Reference for MUL mode at W=24, FRAC=22, round half up: returns {sat, p}.
  function automatic logic [24:0] model_mul(input logic [23:0] a, input logic [23:0] b);
    logic signed [47:0] p;
    logic signed [48:0] t;
    p = 48'($signed(a)) * 48'($signed(b));
    t = (49'(p) + 49'sd2097152) >>> 22;
    if (t > 49'sd8388607)  return {1'b1, 24'h7FFFFF};
    if (t < -49'sd8388608) return {1'b1, 24'h800000};
    return {1'b0, t[23:0]};
  endfunction

  task automatic idle_all();
    if_r.in_valid = 1'b0; if_r.in_a = '0; if_r.in_b = '0; if_r.in_mode = MODE_MUL; if_r.out_ready = 1'b1;
    if_t.in_valid = 1'b0; if_t.in_a = '0; if_t.in_b = '0; if_t.in_mode = MODE_MUL; if_t.out_ready = 1'b1;
    if_s.in_valid = 1'b0; if_s.in_a = '0; if_s.in_b = '0; if_s.in_mode = MODE_MUL; if_s.out_ready = 1'b1;
  endtask

  // One item into both W=24 instances; waits (bounded) for its result.
  task automatic send24(input logic [23:0] a, input logic [23:0] b, input logic [1:0] mode,
                        output logic [23:0] p_r, output logic sat_r,
                        output logic [23:0] p_t, output logic sat_t);
    int cyc;
    @(negedge clk);
    if_r.in_valid = 1'b1; if_r.in_a = a; if_r.in_b = b; if_r.in_mode = mode;
    if_t.in_valid = 1'b1; if_t.in_a = a; if_t.in_b = b; if_t.in_mode = mode;
    @(negedge clk);
    if_r.in_valid = 1'b0;
    if_t.in_valid = 1'b0;
    cyc = 1;
    while (!if_r.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (if_r.out_valid !== 1'b1) $display("FAIL send24_timeout: out_valid=%b after %0d cycles, required 1", if_r.out_valid, cyc);
    else n_pass++;
    p_r = if_r.out_p; sat_r = if_r.out_sat;
    p_t = if_t.out_p; sat_t = if_t.out_sat;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode,
                       output logic [7:0] p, output logic sat, output logic ovf);
    int cyc;
    @(negedge clk);
    if_s.in_valid = 1'b1; if_s.in_a = a; if_s.in_b = b; if_s.in_mode = mode;
    @(negedge clk);
    if_s.in_valid = 1'b0;
    cyc = 1;
    while (!if_s.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (if_s.out_valid !== 1'b1) $display("FAIL send8_timeout: out_valid=%b after %0d cycles, required 1", if_s.out_valid, cyc);
    else n_pass++;
    p = if_s.out_p; sat = if_s.out_sat; ovf = if_s.acc_ovf;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({if_r.out_valid, if_r.out_sat, if_r.acc_ovf, if_r.in_ready} !== 4'b0001)
      $display("FAIL reset_ctl: {out_valid,out_sat,acc_ovf,in_ready}=%b, required 0001",
               {if_r.out_valid, if_r.out_sat, if_r.acc_ovf, if_r.in_ready});
    else n_pass++;
    n_total++;
    if (if_r.out_p !== 24'h0) $display("FAIL reset_out_p: got %h, required 000000", if_r.out_p);
    else n_pass++;
    n_total++;
    if ({if_s.out_p, if_s.acc_ovf, if_s.in_ready} !== 10'b0000_0000_01)
      $display("FAIL reset_narrow: {out_p,acc_ovf,in_ready}=%b, required 0000000001", {if_s.out_p, if_s.acc_ovf, if_s.in_ready});
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [23:0] va [4];
    logic [23:0] vb [4];
    logic [1:0]  vm [4];
    logic [23:0] ep [4];
    logic        es [4];
    logic [23:0] pr, pt;
    logic        sr, st;
    va = '{24'h400000, 24'h600000, 24'h800000, 24'hC00000};
    vb = '{24'h400000, 24'h600000, 24'h7FFFFF, 24'h400000};
    vm = '{MODE_MUL, MODE_MUL, MODE_MUL, MODE_MUL_ALT};
    ep = '{24'h400000, 24'h7FFFFF, 24'h800000, 24'hC00000};
    es = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send24(va[i], vb[i], vm[i], pr, sr, pt, st);
      n_total++;
      if (pr !== ep[i]) $display("FAIL sat_p[%0d]: got %h, required %h", i, pr, ep[i]);
      else n_pass++;
      n_total++;
      if (sr !== es[i]) $display("FAIL sat_flag[%0d]: got %b, required %b", i, sr, es[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rounding();
    logic [23:0] pr, pt;
    logic        sr, st;
    send24(24'h000001, 24'h200000, MODE_MUL, pr, sr, pt, st);
    n_total++;
    if (pr !== 24'h000001) $display("FAIL round_pos_half: got %h, required 000001", pr);
    else n_pass++;
    n_total++;
    if (pt !== 24'h000000) $display("FAIL trunc_pos_half: got %h, required 000000", pt);
    else n_pass++;
    send24(24'hFFFFFF, 24'h200000, MODE_MUL, pr, sr, pt, st);
    n_total++;
    if (pr !== 24'h000000) $display("FAIL round_neg_half: got %h, required 000000", pr);
    else n_pass++;
    n_total++;
    if (pt !== 24'hFFFFFF) $display("FAIL trunc_neg_half: got %h, required FFFFFF", pt);
    else n_pass++;
  endtask

  // Four items back to back; results expected on consecutive cycles 5 edges after the first accept.
  task automatic test_mac_chain();
    logic [23:0] exp_p;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_total++;
      if (if_r.out_valid !== (k >= 5)) $display("FAIL chain_valid[%0d]: got %b, required %b", k, if_r.out_valid, (k >= 5));
      else n_pass++;
      if (k >= 5) begin
        exp_p = 24'(k - 4) << 20;
        n_total++;
        if (if_r.out_p !== exp_p) $display("FAIL chain_p[%0d]: got %h, required %h", k, if_r.out_p, exp_p);
        else n_pass++;
      end
      if (k < 4) begin
        if_r.in_valid = 1'b1; if_r.in_a = 24'h200000; if_r.in_b = 24'h200000;
        if_r.in_mode = (k == 0) ? MODE_MAC_CLR : MODE_MAC;
      end else begin
        if_r.in_valid = 1'b0;
      end
    end
    n_total++;
    if (if_r.acc_ovf !== 1'b0) $display("FAIL chain_ovf: got %b, required 0", if_r.acc_ovf);
    else n_pass++;
  endtask

  task automatic test_acc_clamp();
    logic [7:0] p;
    logic       sat, ovf;
    send8(8'h80, 8'h80, MODE_MAC_CLR, p, sat, ovf);
    n_total++;
    if ({ovf, sat, p} !== {1'b0, 1'b1, 8'h7F}) $display("FAIL clamp_clr: {ovf,sat,p}=%b_%b_%h, required 0_1_7f", ovf, sat, p);
    else n_pass++;
    send8(8'h80, 8'h80, MODE_MAC, p, sat, ovf);
    n_total++;
    if ({ovf, sat, p} !== {1'b1, 1'b1, 8'h7F}) $display("FAIL clamp_first: {ovf,sat,p}=%b_%b_%h, required 1_1_7f", ovf, sat, p);
    else n_pass++;
    send8(8'h80, 8'h80, MODE_MAC, p, sat, ovf);
    n_total++;
    if (ovf !== 1'b1) $display("FAIL clamp_sticky: acc_ovf=%b, required 1", ovf);
    else n_pass++;
    send8(8'h40, 8'h40, MODE_MUL, p, sat, ovf);
    n_total++;
    if ({ovf, sat, p} !== {1'b1, 1'b0, 8'h40}) $display("FAIL clamp_mul: {ovf,sat,p}=%b_%b_%h, required 1_0_40", ovf, sat, p);
    else n_pass++;
    // acc at 32767 minus 32800 lands at -33, which rounds to -1; an unclamped 32768 would give 0
    for (int i = 0; i < 4; i++) send8(8'h40, 8'h80, MODE_MAC, p, sat, ovf);
    send8(8'hF8, 8'h04, MODE_MAC, p, sat, ovf);
    n_total++;
    if ({ovf, sat, p} !== {1'b1, 1'b0, 8'hFF}) $display("FAIL clamp_value: {ovf,sat,p}=%b_%b_%h, required 1_0_ff", ovf, sat, p);
    else n_pass++;
    send8(8'h40, 8'h40, MODE_MAC_CLR, p, sat, ovf);
    n_total++;
    if ({ovf, sat, p} !== {1'b0, 1'b0, 8'h40}) $display("FAIL clamp_reclr: {ovf,sat,p}=%b_%b_%h, required 0_0_40", ovf, sat, p);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [24:0] q [$];
    logic [24:0] exp_w, got_w;
    logic [23:0] na, nb, held;
    logic        took, gave, stall;
    int          n_in, n_out;
    n_in = 0; n_out = 0; held = '0;
    na = 24'($urandom); nb = 24'($urandom);
    for (int cyc = 0; cyc < 80 && (n_in < 24 || q.size() != 0); cyc++) begin
      @(negedge clk);
      stall = (cyc >= 10 && cyc < 13);
      if_r.in_valid = (n_in < 24); if_r.in_a = na; if_r.in_b = nb; if_r.in_mode = MODE_MUL;
      if_r.out_ready = !stall;
      #1;
      if (stall) begin
        n_total++;
        if (if_r.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b, required 0", cyc, if_r.in_ready);
        else n_pass++;
        if (cyc == 10) held = if_r.out_p;
        else begin
          n_total++;
          if (if_r.out_p !== held) $display("FAIL bp_hold[%0d]: got %h, required %h", cyc, if_r.out_p, held);
          else n_pass++;
        end
      end
      gave = if_r.out_valid && if_r.out_ready;
      took = if_r.in_valid && if_r.in_ready;
      if (gave) begin
        got_w = {if_r.out_sat, if_r.out_p};
        n_out++;
        n_total++;
        if (q.size() == 0) $display("FAIL bp_extra[%0d]: got %h, required no output", cyc, got_w);
        else begin
          exp_w = q.pop_front();
          if (got_w !== exp_w) $display("FAIL bp_data[%0d]: got %h, required %h", n_out - 1, got_w, exp_w);
          else n_pass++;
        end
      end
      if (took) begin
        q.push_back(model_mul(na, nb));
        n_in++;
        na = 24'($urandom); nb = 24'($urandom);
      end
    end
    @(negedge clk);
    if_r.in_valid = 1'b0;
    if_r.out_ready = 1'b1;
    n_total++;
    if (n_out != 24 || q.size() != 0) $display("FAIL bp_count: outputs %0d pending %0d, required 24 and 0", n_out, q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int lat;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if_r.in_valid = 1'b1; if_r.in_a = 24'h600000; if_r.in_b = 24'h600000; if_r.in_mode = MODE_MAC_CLR;
    end
    @(negedge clk);
    if_r.in_valid = 1'b0;
    #1;
    n_total++;
    if ({if_r.out_valid, if_r.out_p} !== {1'b1, 24'h7FFFFF})
      $display("FAIL pre_reset_out: {out_valid,out_p}=%b_%h, required 1_7fffff", if_r.out_valid, if_r.out_p);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({if_r.out_valid, if_r.out_sat, if_r.acc_ovf, if_r.in_ready} !== 4'b0001)
      $display("FAIL midreset_ctl: {out_valid,out_sat,acc_ovf,in_ready}=%b, required 0001",
               {if_r.out_valid, if_r.out_sat, if_r.acc_ovf, if_r.in_ready});
    else n_pass++;
    n_total++;
    if (if_r.out_p !== 24'h0) $display("FAIL midreset_out_p: got %h, required 000000", if_r.out_p);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_r.in_valid = 1'b1; if_r.in_a = 24'h200000; if_r.in_b = 24'h200000; if_r.in_mode = MODE_MAC;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if_r.in_valid = 1'b0;
    while (!if_r.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_total++;
    if (lat !== 5) $display("FAIL post_reset_latency: got %0d, required 5", lat);
    else n_pass++;
    n_total++;
    if ({if_r.out_sat, if_r.out_p} !== {1'b0, 24'h100000})
      $display("FAIL post_reset_mac: {out_sat,out_p}=%b_%h, required 0_100000", if_r.out_sat, if_r.out_p);
    else n_pass++;
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_saturation();
    test_rounding();
    test_mac_chain();
    test_acc_clamp();
    test_backpressure();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
